// File: rtl/exe_hazard_ctrl_pkg.sv
// Package: exe_ctrl_pkg
// Purpose: shared opcodes and the multi-cycle sequencer state type used by
//          the execute-stage hazard controller and its sub-module.
// Contents:
//   OP_LOAD, OP_LOAD_FP : execute-stage opcodes that produce a load-use hazard
//   mc_state_t          : IDLE / BUSY / DONE states of the multi-cycle unit
package exe_ctrl_pkg;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP = 7'b0000111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

endpackage : exe_ctrl_pkg

// File: rtl/exe_hazard_ctrl_if.sv
// Interface: exe_hazard_ctrl_if
// Purpose: bundles the decode/execute hazard inputs and the pipeline
//          stall/flush/multi-cycle controls exchanged between the pipeline
//          datapath and the hazard controller.
// Modports:
//   master : pipeline side, drives decode/execute info, receives controls
//   slave  : hazard controller side, receives info, drives controls
interface exe_hazard_ctrl_if;

    logic [4:0] D_rs1;
    logic [4:0] D_rs2;
    logic [4:0] D_rs1_f;
    logic [4:0] D_rs2_f;
    logic       D_use_rs1;
    logic       D_use_rs2;
    logic       D_use_rs1_f;
    logic       D_use_rs2_f;
    logic [6:0] E_op;
    logic [4:0] E_rd;
    logic [4:0] E_rd_f;
    logic       E_mc_valid;
    logic       next_pc_sel;

    logic       stall_F;
    logic       stall_D;
    logic       stall_E;
    logic       flush_D;
    logic       flush_E;
    logic       mc_start;
    logic       mc_done;
    logic       mc_busy;

    modport master (
        output D_rs1, D_rs2, D_rs1_f, D_rs2_f,
        output D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f,
        output E_op, E_rd, E_rd_f, E_mc_valid, next_pc_sel,
        input  stall_F, stall_D, stall_E, flush_D, flush_E,
        input  mc_start, mc_done, mc_busy
    );

    modport slave (
        input  D_rs1, D_rs2, D_rs1_f, D_rs2_f,
        input  D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f,
        input  E_op, E_rd, E_rd_f, E_mc_valid, next_pc_sel,
        output stall_F, stall_D, stall_E, flush_D, flush_E,
        output mc_start, mc_done, mc_busy
    );

endinterface : exe_hazard_ctrl_if

// File: rtl/exe_hazard_ctrl_mc_sequencer.sv
// Module: mc_sequencer
// Purpose: IDLE/BUSY/DONE sequencer for the shared multi-cycle unit.
//          A request seen in IDLE issues a one-cycle start (combinational on
//          the request) and loads a countdown; BUSY lasts MC_LATENCY-1
//          cycles, then DONE pulses for one cycle and the FSM returns to IDLE.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   start_req  : execute instr needs the multi-cycle unit
//   busy       : registered, high while in BUSY
//   start      : launch pulse, high in IDLE while start_req is high
//   done       : registered, one-cycle pulse in DONE
module mc_sequencer
    import exe_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    output logic busy,
    output logic start,
    output logic done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mc_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             start_s;

    // Launch pulse: only an idle sequencer accepts a new request.
    always_comb begin
        start_s = 1'b0;
        if ((state_r == MC_IDLE) && start_req) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // FSM, countdown and registered busy/done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= MC_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                MC_IDLE: begin
                    done_r <= 1'b0;
                    if (start_req) begin
                        state_r <= MC_BUSY;
                        cnt_r   <= CNT_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                MC_BUSY: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= MC_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                MC_DONE: begin
                    // A request still present here is the next op; it is
                    // taken from IDLE on the following cycle.
                    state_r <= MC_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= MC_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign start = start_s;

endmodule : mc_sequencer

// File: rtl/exe_hazard_ctrl.sv
// Module: exe_hazard_ctrl
// Purpose: stall/flush sequencer around the execute stage. Detects int and
//          FP load-use hazards, squashes wrong-path instrs on a taken
//          branch/jump, and freezes F/D/E while the shared multi-cycle unit
//          (DIV/REM/FDIV/FSQRT) works.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   hz       : exe_hazard_ctrl_if.slave (decode/execute info in,
//              stall/flush/multi-cycle controls out)
//   stall_cnt, flush_cnt : present only with HAZARD_STATS_EN defined;
//              cycles with stall_D / flush_D high, wrapping at 2**32
// Configuration macro: HAZARD_STATS_EN
module exe_hazard_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 8,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    exe_hazard_ctrl_if.slave   hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    logic int_lu_s;
    logic fp_lu_s;
    logic seq_idle_s;
    logic load_use_s;
    logic jump_s;
    logic start_req_s;
    logic mc_busy_s;
    logic mc_start_s;
    logic mc_done_s;
    logic freeze_s;

    logic stall_f_s;
    logic stall_d_s;
    logic stall_e_s;
    logic flush_d_s;
    logic flush_e_s;
    logic mc_start_o_s;
    logic mc_done_o_s;
    logic mc_busy_o_s;

    // Load-use detection; x0 never carries a dependency, f0 does.
    always_comb begin
        int_lu_s = (hz.E_op == OP_LOAD) && (hz.E_rd != 5'd0) &&
                   (((hz.E_rd == hz.D_rs1) && hz.D_use_rs1) ||
                    ((hz.E_rd == hz.D_rs2) && hz.D_use_rs2));
        fp_lu_s  = (hz.E_op == OP_LOAD_FP) &&
                   (((hz.E_rd_f == hz.D_rs1_f) && hz.D_use_rs1_f) ||
                    ((hz.E_rd_f == hz.D_rs2_f) && hz.D_use_rs2_f));
    end

    // A branch resolving in the same cycle wins over a multi-cycle issue.
    assign start_req_s = hz.E_mc_valid && !hz.next_pc_sel;

    mc_sequencer #(
        .MC_LATENCY (MC_LATENCY),
        .CNT_W      (CNT_W)
    ) u_mc_seq (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req_s),
        .busy      (mc_busy_s),
        .start     (mc_start_s),
        .done      (mc_done_s)
    );

    // While BUSY or DONE the pipeline is frozen/advancing the mc instr, so
    // hazard and branch inputs are not acted on.
    always_comb begin
        seq_idle_s = !mc_busy_s && !mc_done_s;
        load_use_s = (int_lu_s || fp_lu_s) && seq_idle_s;
        jump_s     = hz.next_pc_sel && seq_idle_s;
        freeze_s   = mc_start_s || mc_busy_s;
    end

    // Output priority: freeze > jump > load-use; everything low in reset.
    always_comb begin
        stall_f_s    = 1'b0;
        stall_d_s    = 1'b0;
        stall_e_s    = 1'b0;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        mc_start_o_s = 1'b0;
        mc_done_o_s  = 1'b0;
        mc_busy_o_s  = 1'b0;
        if (!rst) begin
            stall_f_s    = 1'b0;
        end else begin
            stall_f_s    = freeze_s || (load_use_s && !jump_s);
            stall_d_s    = freeze_s || (load_use_s && !jump_s);
            stall_e_s    = freeze_s;
            flush_d_s    = jump_s && !freeze_s;
            flush_e_s    = (jump_s || load_use_s) && !freeze_s;
            mc_start_o_s = mc_start_s;
            mc_done_o_s  = mc_done_s;
            mc_busy_o_s  = mc_busy_s;
        end
    end

    assign hz.stall_F  = stall_f_s;
    assign hz.stall_D  = stall_d_s;
    assign hz.stall_E  = stall_e_s;
    assign hz.flush_D  = flush_d_s;
    assign hz.flush_E  = flush_e_s;
    assign hz.mc_start = mc_start_o_s;
    assign hz.mc_done  = mc_done_o_s;
    assign hz.mc_busy  = mc_busy_o_s;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running stall/flush event counters, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_d_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_d_s) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule : exe_hazard_ctrl

// File: tb/tb_exe_hazard_ctrl.sv
// Testbench: tb_exe_hazard_ctrl
// Purpose: directed vectors for exe_hazard_ctrl with hand-computed expected
//          control vectors. The observed vector is packed as
//          {stall_F, stall_D, stall_E, flush_D, flush_E, mc_start, mc_done, mc_busy}.
// Stats counters are checked when HAZARD_STATS_EN is defined.
module tb_exe_hazard_ctrl;

    localparam int LAT = 8;

    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_LU    = 8'b1100_1000;
    localparam logic [7:0] V_JUMP  = 8'b0001_1000;
    localparam logic [7:0] V_START = 8'b1110_0100;
    localparam logic [7:0] V_BUSY  = 8'b1110_0001;
    localparam logic [7:0] V_DONE  = 8'b0000_0010;

    logic clk;
    logic rst;
    logic [7:0] obs;
    int n_cmp;
    int n_err;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    exe_hazard_ctrl_if hif ();

    exe_hazard_ctrl #(
        .MC_LATENCY (LAT),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    assign obs = {hif.stall_F, hif.stall_D, hif.stall_E, hif.flush_D,
                  hif.flush_E, hif.mc_start, hif.mc_done, hif.mc_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        hif.D_rs1       = 5'd0;
        hif.D_rs2       = 5'd0;
        hif.D_rs1_f     = 5'd0;
        hif.D_rs2_f     = 5'd0;
        hif.D_use_rs1   = 1'b0;
        hif.D_use_rs2   = 1'b0;
        hif.D_use_rs1_f = 1'b0;
        hif.D_use_rs2_f = 1'b0;
        hif.E_op        = 7'b0010011;
        hif.E_rd        = 5'd0;
        hif.E_rd_f      = 5'd0;
        hif.E_mc_valid  = 1'b0;
        hif.next_pc_sel = 1'b0;
    endtask

    task automatic set_lw_x5();
        set_nop();
        hif.E_op      = 7'b0000011;
        hif.E_rd      = 5'd5;
        hif.D_rs1     = 5'd3;
        hif.D_use_rs1 = 1'b1;
        hif.D_rs2     = 5'd5;
        hif.D_use_rs2 = 1'b1;
    endtask

    task automatic set_div();
        set_nop();
        hif.E_op       = 7'b0110011;
        hif.E_rd       = 5'd9;
        hif.E_mc_valid = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        set_nop();
        #12;
        check_val("reset_outs", {24'd0, obs}, {24'd0, V_IDLE});
        nxt();
        rst = 1'b1;
        #1;
        check_val("idle_after_reset", {24'd0, obs}, {24'd0, V_IDLE});

        // Int load-use through rs2, then bubble: one-cycle stall.
        nxt(); set_lw_x5(); #1;
        check_val("lw_x5_rs2", {24'd0, obs}, {24'd0, V_LU});
        nxt(); set_nop(); #1;
        check_val("lw_x5_after", {24'd0, obs}, {24'd0, V_IDLE});

        // Matching register but operand not read.
        nxt(); set_lw_x5(); hif.D_use_rs2 = 1'b0; #1;
        check_val("lw_x5_unused", {24'd0, obs}, {24'd0, V_IDLE});

        // x0 destination never stalls.
        nxt(); set_nop(); hif.E_op = 7'b0000011; hif.E_rd = 5'd0;
        hif.D_use_rs1 = 1'b1; hif.D_use_rs2 = 1'b1; #1;
        check_val("lw_x0", {24'd0, obs}, {24'd0, V_IDLE});

        // FLW f0: f0 is a real register.
        nxt(); set_nop(); hif.E_op = 7'b0000111; hif.E_rd_f = 5'd0;
        hif.D_rs1_f = 5'd0; hif.D_use_rs1_f = 1'b1; #1;
        check_val("flw_f0", {24'd0, obs}, {24'd0, V_LU});
        nxt(); set_nop(); #1;
        check_val("flw_f0_after", {24'd0, obs}, {24'd0, V_IDLE});

        // Int load whose rd only matches an FP source: no hazard.
        nxt(); set_nop(); hif.E_op = 7'b0000011; hif.E_rd = 5'd7;
        hif.D_rs2_f = 5'd7; hif.D_use_rs2_f = 1'b1; #1;
        check_val("lw_fp_cross", {24'd0, obs}, {24'd0, V_IDLE});

        // Load-use together with a taken branch: branch wins.
        nxt(); set_lw_x5(); hif.next_pc_sel = 1'b1; #1;
        check_val("lu_and_jump", {24'd0, obs}, {24'd0, V_JUMP});
        nxt(); set_nop(); hif.next_pc_sel = 1'b1; #1;
        check_val("jump_only", {24'd0, obs}, {24'd0, V_JUMP});

        // Branch and mc request together: no issue, just the flush.
        nxt(); set_div(); hif.next_pc_sel = 1'b1; #1;
        check_val("mc_and_jump", {24'd0, obs}, {24'd0, V_JUMP});

        // Single multi-cycle op: start at T, busy T+1..T+7, done at T+8.
        nxt(); set_div(); #1;
        check_val("mc_start", {24'd0, obs}, {24'd0, V_START});
        for (int i = 1; i < LAT; i++) begin
            nxt();
            if (i == 3) begin
                hif.next_pc_sel = 1'b1;
                hif.E_op = 7'b0000011; hif.E_rd = 5'd5;
                hif.D_rs1 = 5'd5; hif.D_use_rs1 = 1'b1;
            end else begin
                set_div();
            end
            #1;
            check_val("mc_busy", {24'd0, obs}, {24'd0, V_BUSY});
        end
        nxt(); set_nop(); #1;
        check_val("mc_done", {24'd0, obs}, {24'd0, V_DONE});
        nxt(); #1;
        check_val("mc_after_done", {24'd0, obs}, {24'd0, V_IDLE});

        // Back-to-back ops: request held through DONE issues next cycle.
        nxt(); set_div(); #1;
        check_val("b2b_start1", {24'd0, obs}, {24'd0, V_START});
        for (int i = 1; i < LAT; i++) begin
            nxt(); #1;
            check_val("b2b_busy1", {24'd0, obs}, {24'd0, V_BUSY});
        end
        nxt(); #1;
        check_val("b2b_done1", {24'd0, obs}, {24'd0, V_DONE});
        nxt(); #1;
        check_val("b2b_start2", {24'd0, obs}, {24'd0, V_START});
        for (int i = 1; i < LAT; i++) begin
            nxt(); #1;
            check_val("b2b_busy2", {24'd0, obs}, {24'd0, V_BUSY});
        end
        nxt(); set_nop(); #1;
        check_val("b2b_done2", {24'd0, obs}, {24'd0, V_DONE});

        // Reset at BUSY cycle 3.
        nxt(); set_div(); #1;
        check_val("rst_mid_start", {24'd0, obs}, {24'd0, V_START});
        for (int i = 1; i <= 3; i++) begin
            nxt(); #1;
            check_val("rst_mid_busy", {24'd0, obs}, {24'd0, V_BUSY});
        end
        rst = 1'b0;
        set_nop();
        #1;
        check_val("rst_mid_async", {24'd0, obs}, {24'd0, V_IDLE});
        nxt(); #1;
        check_val("rst_mid_held", {24'd0, obs}, {24'd0, V_IDLE});
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nxt(); #1;
            check_val("rst_mid_no_done", {24'd0, obs}, {24'd0, V_IDLE});
        end
        nxt(); set_div(); #1;
        check_val("restart_start", {24'd0, obs}, {24'd0, V_START});
        for (int i = 1; i < LAT; i++) begin
            nxt(); #1;
            check_val("restart_busy", {24'd0, obs}, {24'd0, V_BUSY});
        end
        nxt(); set_nop(); #1;
        check_val("restart_done", {24'd0, obs}, {24'd0, V_DONE});

`ifdef HAZARD_STATS_EN
        // Fresh counters: 3 load-use stalls and 2 jumps.
        nxt(); rst = 1'b0; #1;
        check_val("stats_reset_s", stall_cnt, 32'd0);
        check_val("stats_reset_f", flush_cnt, 32'd0);
        nxt(); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt(); set_lw_x5(); #1;
            nxt(); set_nop(); #1;
        end
        for (int i = 0; i < 2; i++) begin
            nxt(); set_nop(); hif.next_pc_sel = 1'b1; #1;
        end
        nxt(); set_nop(); #1;
        check_val("stall_cnt", stall_cnt, 32'd3);
        check_val("flush_cnt", flush_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_exe_hazard_ctrl
